id_stage_hs: RTL
================

Name: id_stage_hs

Overview:
- Parametrised next-generation RV32I decode stage: register file, instruction decode, load-use hazard detection and ID/EX pipeline register.
- Replaces the stall/flush-only control with valid/ready handshakes on both sides.
- Adds LUI/AUIPC decode, illegal-instruction flagging, and write-back bypass into held operands.
- Sits between the fetch stage (upstream) and the ALU/execute stage (downstream).

Parameters:
- XLEN, 32, datapath/register width (32 or 64).
- REG_COUNT, 32, architectural registers; power of two, 2..32; index width RW = clog2(REG_COUNT). Instruction register fields are truncated to RW bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- in_instr  in  32  instruction.
- in_pc  in  XLEN  instruction PC.
- in_pred_taken  in  1  fetch prediction bit.
- flush  in  1  kill ID contents and incoming instruction.
- wb_en  in  1  write-back enable.
- wb_addr  in  RW  write-back register.
- wb_data  in  XLEN  write-back data.
- out_valid  out  1  ID/EX register holds an instruction.
- out_ready  in  1  execute accepts.
- out_rd, out_rs1, out_rs2  out  RW each  register indices.
- out_data1, out_data2  out  XLEN each  operand values.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  PC.
- out_pred_taken  out  1  prediction bit.
- out_is_branch  out  1  BEQ/BNE/JAL/JALR.
- out_branch_type  out  2  JAL=0, JALR=1, BEQ=2, BNE=3.
- out_alu_op  out  4  ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8.
- out_alu_src  out  1  1 selects immediate as operand B.
- out_pc_src  out  1  1 selects PC as operand A (AUIPC).
- out_mem  out  2  bit1 = read, bit0 = write.
- out_wb  out  1  register write-back.
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Reset: all out_* = 0 (out_branch_type = 0); regfile cleared; in_ready = 0 while rst is high.
- Decoded opcodes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011 (funct3 000/001 only), JALR 1100111, JAL 1101111, LUI 0110111, AUIPC 0010111.
  - Anything else (including other branch funct3): out_illegal = 1, out_wb = 0, out_mem = 00, rd = rs1 = rs2 = 0, imm = 0.
- Immediates:
  - I, S, B and J formats as in RV32I.
  - U format = {instr[31:12], 12'b0}, sign-extended to XLEN.
- Unused source fields are forced to 0: rs2 for I/LOAD/JALR/U/J; rs1 for U/J.
- ALU decode:
  - R: funct3/funct7[5] select the op.
  - I-ALU: funct7[5] honoured only for funct3 = 101.
  - LOAD/STORE/JAL/JALR/LUI/AUIPC: ADD.
  - BEQ/BNE: SUB.
- Operand selects:
  - out_alu_src = 0 for R and BRANCH, else 1.
  - out_pc_src = 1 only for AUIPC.
  - LUI: rs1 = 0, so data1 = 0.
- Write-back flag: out_wb = 1 for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC.
- Register file:
  - Write when wb_en and wb_addr != 0, regardless of any stall or hazard.
  - Read is write-first: a same-cycle wb to the same rs returns wb_data.
  - x0 always reads 0.
- Definitions:
  - adv = !out_valid || out_ready.
  - hazard = in_valid && out_valid && out_mem[1] && out_rd != 0 && (out_rd == dec_rs1 || out_rd == dec_rs2). dec_rs1/dec_rs2 are the post-forcing indices.
- in_ready = adv && !hazard && !rst.
- Next-state priority: rst > flush > adv.
  - flush: out_valid <= 0; incoming instruction dropped; in_ready still asserted. No bubble-counter effects.
  - adv with accept (in_valid && in_ready): load decoded fields; out_valid <= 1. Latency 1 cycle.
  - adv with hazard or !in_valid: out_valid <= 0 (bubble). Payload registers may be left unchanged; execute must qualify on out_valid.
  - !adv (downstream stall): all out_* held.
- Held-operand patch: while the register is held (!adv), any wb_en with wb_addr != 0 matching out_rs1 or out_rs2 overwrites out_data1/out_data2.
- The hazard clears the cycle after the load leaves. Exactly one bubble is inserted when out_ready = 1.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bubbles [31:0] and perf_flushes [31:0], both cleared on rst.
  - perf_bubbles increments each cycle adv && in_valid && hazard && !flush.
  - perf_flushes increments each cycle flush is high and out_valid was 1.
  - Both saturate at all-ones.
- Undefined: no counters and no ports; behaviour otherwise identical.

Decomposition:
- Package id_pkg: opcode constants, ALU op constants, branch-type constants, instruction-format enum, decoded-control struct.
- Sub-module id_regfile: parameters XLEN and REG_COUNT; two write-first read ports; one write port; x0 hardwired to zero.
- Decode, hazard and handshake logic stay in id_stage_hs.

Test Plan:
- Reset then feed addi x5,x0,-3 (0xFFD00293) with out_ready = 1.
  - Next cycle: out_valid = 1, rd = 5, imm = 0xFFFFFFFD, alu_op = ADD, alu_src = 1, out_wb = 1.
- Feed lw x6,0(x1), then add x7,x6,x2.
  - Cycle after the lw is accepted: in_ready = 0 for 1 cycle.
  - One bubble (out_valid = 0), then the add issues. With ID_PERF_CNT_EN, perf_bubbles = 1.
- Hold out_ready = 0 with add x3,x1,x2 in the register; pulse wb_en with x1 = 0x1234.
  - out_data1 becomes 0x1234; all other outputs are stable.
- Write x9 = 0xABCD via wb while decoding or x4,x9,x0 in the same cycle.
  - out_data1 = 0xABCD (write-first bypass).
- Assert flush with in_valid = 1 and out_valid = 1.
  - Next cycle out_valid = 0; the instruction is dropped.
  - Feed auipc x1,0x1 at PC 0x100: imm = 0x1000, out_pc_src = 1.
- Feed opcode 0x0000007F.
  - out_illegal = 1, out_wb = 0, out_mem = 00.
  - Rerun with REG_COUNT = 16: write to x17 lands in x1.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the id_stage_hs decode stage.
// Optional feature macro used by the top: ID_PERF_CNT_EN.
package id_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SRA = 4'd7;
   localparam logic [3:0] ALU_SLT = 4'd8;

   localparam logic [1:0] BR_JAL  = 2'd0;
   localparam logic [1:0] BR_JALR = 2'd1;
   localparam logic [1:0] BR_BEQ  = 2'd2;
   localparam logic [1:0] BR_BNE  = 2'd3;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5,
      FMT_X = 3'd6
   } fmt_e;

   typedef struct packed {
      fmt_e       fmt;
      logic       use_rs1;
      logic       use_rs2;
      logic       is_branch;
      logic [1:0] branch_type;
      logic [3:0] alu_op;
      logic       alu_src;
      logic       pc_src;
      logic [1:0] mem;
      logic       wb;
      logic       illegal;
   } ctrl_t;

   // funct3/funct7[5] to ALU op; register ops always honour funct7[5],
   // immediate ops only for the shift-right group. SLTU shares the SLT op.
   function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                 input logic       f7b5,
                                                 input logic       is_reg);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLT;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // Opcode-level control decode; anything unrecognised is flagged illegal
   // with every side-effect flag cleared.
   function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
      ctrl_t c;
      c        = '0;
      c.fmt    = FMT_X;
      c.alu_op = ALU_ADD;
      case (instr[6:0])
         OPC_R: begin
            c.fmt     = FMT_R;
            c.use_rs1 = 1'b1;
            c.use_rs2 = 1'b1;
            c.alu_op  = alu_from_funct(instr[14:12], instr[30], 1'b1);
            c.wb      = 1'b1;
         end
         OPC_I: begin
            c.fmt     = FMT_I;
            c.use_rs1 = 1'b1;
            c.alu_op  = alu_from_funct(instr[14:12], instr[30], 1'b0);
            c.alu_src = 1'b1;
            c.wb      = 1'b1;
         end
         OPC_LOAD: begin
            c.fmt     = FMT_I;
            c.use_rs1 = 1'b1;
            c.alu_src = 1'b1;
            c.mem     = 2'b10;
            c.wb      = 1'b1;
         end
         OPC_STORE: begin
            c.fmt     = FMT_S;
            c.use_rs1 = 1'b1;
            c.use_rs2 = 1'b1;
            c.alu_src = 1'b1;
            c.mem     = 2'b01;
         end
         OPC_BRANCH: begin
            if (instr[14:13] == 2'b00) begin
               c.fmt         = FMT_B;
               c.use_rs1     = 1'b1;
               c.use_rs2     = 1'b1;
               c.is_branch   = 1'b1;
               c.branch_type = instr[12] ? BR_BNE : BR_BEQ;
               c.alu_op      = ALU_SUB;
            end else begin
               c.illegal = 1'b1;
            end
         end
         OPC_JALR: begin
            c.fmt         = FMT_I;
            c.use_rs1     = 1'b1;
            c.is_branch   = 1'b1;
            c.branch_type = BR_JALR;
            c.alu_src     = 1'b1;
            c.wb          = 1'b1;
         end
         OPC_JAL: begin
            c.fmt         = FMT_J;
            c.is_branch   = 1'b1;
            c.branch_type = BR_JAL;
            c.alu_src     = 1'b1;
            c.wb          = 1'b1;
         end
         OPC_LUI: begin
            c.fmt     = FMT_U;
            c.alu_src = 1'b1;
            c.wb      = 1'b1;
         end
         OPC_AUIPC: begin
            c.fmt     = FMT_U;
            c.alu_src = 1'b1;
            c.pc_src  = 1'b1;
            c.wb      = 1'b1;
         end
         default: begin
            c.illegal = 1'b1;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two write-first read ports, one write port,
// x0 hardwired to zero, synchronous clear on rst.
module id_regfile
   import id_pkg::*;
#(
   parameter  int XLEN      = 32,
   parameter  int REG_COUNT = 32,
   localparam int RW        = $clog2(REG_COUNT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_we,
   input  logic [RW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [RW-1:0]   i_raddr1,
   input  logic [RW-1:0]   i_raddr2,
   output logic [XLEN-1:0] o_rdata1,
   output logic [XLEN-1:0] o_rdata2
);

   logic [XLEN-1:0] r_regs [REG_COUNT];

   // Register storage: clear on reset, otherwise write any non-zero index.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Read ports: x0 reads zero, a same-cycle write to the same index wins.
   always_comb begin
      if (i_raddr1 == '0) begin
         o_rdata1 = '0;
      end else if (i_we && (i_waddr == i_raddr1)) begin
         o_rdata1 = i_wdata;
      end else begin
         o_rdata1 = r_regs[i_raddr1];
      end
      if (i_raddr2 == '0) begin
         o_rdata2 = '0;
      end else if (i_we && (i_waddr == i_raddr2)) begin
         o_rdata2 = i_wdata;
      end else begin
         o_rdata2 = r_regs[i_raddr2];
      end
   end

endmodule

// File: rtl/id_stage_hs.sv
// RV32I decode stage with valid/ready handshakes, load-use hazard stall,
// write-back bypass into held operands and an ID/EX pipeline register.
// Optional macro ID_PERF_CNT_EN adds saturating bubble/flush counters.
module id_stage_hs
   import id_pkg::*;
#(
   parameter  int XLEN      = 32,
   parameter  int REG_COUNT = 32,
   localparam int RW        = $clog2(REG_COUNT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            in_pred_taken,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [RW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [RW-1:0]   out_rd,
   output logic [RW-1:0]   out_rs1,
   output logic [RW-1:0]   out_rs2,
   output logic [XLEN-1:0] out_data1,
   output logic [XLEN-1:0] out_data2,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc,
   output logic            out_pred_taken,
   output logic            out_is_branch,
   output logic [1:0]      out_branch_type,
   output logic [3:0]      out_alu_op,
   output logic            out_alu_src,
   output logic            out_pc_src,
   output logic [1:0]      out_mem,
   output logic            out_wb,
   output logic            out_illegal
`ifdef ID_PERF_CNT_EN
   ,
   output logic [31:0]     perf_bubbles,
   output logic [31:0]     perf_flushes
`endif
);

   ctrl_t              w_ctrl;
   logic [RW-1:0]      w_rd;
   logic [RW-1:0]      w_rs1;
   logic [RW-1:0]      w_rs2;
   logic signed [31:0] w_imm32;
   logic [XLEN-1:0]    w_imm;
   logic [XLEN-1:0]    w_rdata1;
   logic [XLEN-1:0]    w_rdata2;
   logic               w_adv;
   logic               w_hazard;
   logic               w_ready;
   logic               w_accept;

   logic               r_valid;
   logic [RW-1:0]      r_rd;
   logic [RW-1:0]      r_rs1;
   logic [RW-1:0]      r_rs2;
   logic [XLEN-1:0]    r_data1;
   logic [XLEN-1:0]    r_data2;
   logic [XLEN-1:0]    r_imm;
   logic [XLEN-1:0]    r_pc;
   logic               r_pred_taken;
   logic               r_is_branch;
   logic [1:0]         r_branch_type;
   logic [3:0]         r_alu_op;
   logic               r_alu_src;
   logic               r_pc_src;
   logic [1:0]         r_mem;
   logic               r_wb;
   logic               r_illegal;

   id_regfile #(
      .XLEN      (XLEN),
      .REG_COUNT (REG_COUNT)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .i_we     (wb_en),
      .i_waddr  (wb_addr),
      .i_wdata  (wb_data),
      .i_raddr1 (w_rs1),
      .i_raddr2 (w_rs2),
      .o_rdata1 (w_rdata1),
      .o_rdata2 (w_rdata2)
   );

   // Instruction decode: control, forced register indices, immediate.
   always_comb begin
      w_ctrl = decode_ctrl(in_instr);
      if (w_ctrl.illegal) begin
         w_rd = '0;
      end else begin
         w_rd = in_instr[7 +: RW];
      end
      if (w_ctrl.use_rs1) begin
         w_rs1 = in_instr[15 +: RW];
      end else begin
         w_rs1 = '0;
      end
      if (w_ctrl.use_rs2) begin
         w_rs2 = in_instr[20 +: RW];
      end else begin
         w_rs2 = '0;
      end
      case (w_ctrl.fmt)
         FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
         FMT_U:   w_imm32 = {in_instr[31:12], 12'h000};
         default: w_imm32 = 32'sd0;
      endcase
      // Signed source, so widening to XLEN sign-extends.
      w_imm = XLEN'(w_imm32);
   end

   // Handshake: the register advances when empty or drained; a load in the
   // register whose rd feeds the incoming instruction blocks acceptance.
   always_comb begin
      w_adv    = !r_valid || out_ready;
      w_hazard = in_valid && r_valid && r_mem[1] && (r_rd != '0) &&
                 ((r_rd == w_rs1) || (r_rd == w_rs2));
      w_ready  = w_adv && !w_hazard && !rst;
      w_accept = in_valid && w_ready;
   end

   assign in_ready = w_ready;

   // ID/EX register: reset > flush > advance (load or bubble) > hold with
   // write-back patching of the held operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid       <= 1'b0;
         r_rd          <= '0;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_data1       <= '0;
         r_data2       <= '0;
         r_imm         <= '0;
         r_pc          <= '0;
         r_pred_taken  <= 1'b0;
         r_is_branch   <= 1'b0;
         r_branch_type <= 2'b00;
         r_alu_op      <= 4'd0;
         r_alu_src     <= 1'b0;
         r_pc_src      <= 1'b0;
         r_mem         <= 2'b00;
         r_wb          <= 1'b0;
         r_illegal     <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_adv) begin
         if (w_accept) begin
            r_valid       <= 1'b1;
            r_rd          <= w_rd;
            r_rs1         <= w_rs1;
            r_rs2         <= w_rs2;
            r_data1       <= w_rdata1;
            r_data2       <= w_rdata2;
            r_imm         <= w_imm;
            r_pc          <= in_pc;
            r_pred_taken  <= in_pred_taken;
            r_is_branch   <= w_ctrl.is_branch;
            r_branch_type <= w_ctrl.branch_type;
            r_alu_op      <= w_ctrl.alu_op;
            r_alu_src     <= w_ctrl.alu_src;
            r_pc_src      <= w_ctrl.pc_src;
            r_mem         <= w_ctrl.mem;
            r_wb          <= w_ctrl.wb;
            r_illegal     <= w_ctrl.illegal;
         end else begin
            r_valid <= 1'b0;
         end
      end else begin
         if (wb_en && (wb_addr != '0) && (wb_addr == r_rs1)) begin
            r_data1 <= wb_data;
         end
         if (wb_en && (wb_addr != '0) && (wb_addr == r_rs2)) begin
            r_data2 <= wb_data;
         end
      end
   end

   assign out_valid       = r_valid;
   assign out_rd          = r_rd;
   assign out_rs1         = r_rs1;
   assign out_rs2         = r_rs2;
   assign out_data1       = r_data1;
   assign out_data2       = r_data2;
   assign out_imm         = r_imm;
   assign out_pc          = r_pc;
   assign out_pred_taken  = r_pred_taken;
   assign out_is_branch   = r_is_branch;
   assign out_branch_type = r_branch_type;
   assign out_alu_op      = r_alu_op;
   assign out_alu_src     = r_alu_src;
   assign out_pc_src      = r_pc_src;
   assign out_mem         = r_mem;
   assign out_wb          = r_wb;
   assign out_illegal     = r_illegal;

`ifdef ID_PERF_CNT_EN
   logic [31:0] r_perf_bubbles;
   logic [31:0] r_perf_flushes;

   // Saturating counters for hazard bubbles and flushes that killed a valid entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_bubbles <= 32'd0;
         r_perf_flushes <= 32'd0;
      end else begin
         if (w_adv && in_valid && w_hazard && !flush && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
            r_perf_bubbles <= r_perf_bubbles + 32'd1;
         end
         if (flush && r_valid && (r_perf_flushes != 32'hFFFF_FFFF)) begin
            r_perf_flushes <= r_perf_flushes + 32'd1;
         end
      end
   end

   assign perf_bubbles = r_perf_bubbles;
   assign perf_flushes = r_perf_flushes;
`endif

endmodule
